// File: rtl/booth_divider_32_pkg.sv
// ============================================================================
// Module : arith_pkg
// Brief  : Shared arithmetic-unit types and constants (divider FSM, widths).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/booth_divider_32_if.sv
// ============================================================================
// Module : booth_divider_32_if
// Brief  : Start/ready/valid operand and result bundle for the divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_divider_32_if #(
    parameter int WIDTH = arith_pkg::WIDTH
);
    logic                    start;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic                    ready;
    logic                    valid;
    logic signed [WIDTH-1:0] Q;
    logic signed [WIDTH-1:0] R;
    logic                    div_by_zero;

    modport master (
        output start, A, B,
        input  ready, valid, Q, R, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output ready, valid, Q, R, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/booth_divider_32_step.sv
// ============================================================================
// Module : div_restore_step
// Brief  : One combinational radix-2 restoring shift-compare-subtract step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH:0]   rem_in,
    input  wire logic             dvd_bit,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH:0]   rem_out,
    output logic                  q_bit
);
    logic [WIDTH:0] shifted;
    logic           ge;

    // A set bit shifted out of the top always means the value exceeds the divisor.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], dvd_bit};
        ge      = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
        q_bit   = ge;
        rem_out = ge ? (shifted - {1'b0, divisor}) : shifted;
    end
endmodule

`default_nettype wire

// File: rtl/booth_divider_32.sv
// ============================================================================
// Module : booth_divider_32
// Brief  : Sequential signed divider, one restoring step per cycle, C semantics.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_divider_32 #(
    parameter int WIDTH = arith_pkg::WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    booth_divider_32_if.slave  bus
);
    import arith_pkg::*;

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
    logic             dbz_q, dbz_d, valid_q, valid_d, ready_q, ready_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        q_out_d   = q_out_q;
        r_out_d   = r_out_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    state_d = PREP;
                end
            end
            PREP: begin
                quo_neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                rem_neg_d = a_q[WIDTH-1];
                // Unsigned magnitude of the most negative value is its own bit pattern.
                dvd_d     = a_q[WIDTH-1] ? -a_q : a_q;
                dsr_d     = b_q[WIDTH-1] ? -b_q : b_q;
                rem_d     = '0;
                quo_d     = '0;
                cnt_d     = CW'(WIDTH - 1);
                state_d   = ITER;
            end
            ITER: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (b_q == '0) begin
                    q_out_d = '1;
                    r_out_d = a_q;
                    dbz_d   = 1'b1;
                end else begin
                    q_out_d = quo_neg_q ? -quo_q : quo_q;
                    r_out_d = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            q_out_q   <= '0;
            r_out_q   <= '0;
            dbz_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            q_out_q   <= q_out_d;
            r_out_q   <= r_out_d;
            dbz_q     <= dbz_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.valid       = valid_q;
    assign bus.Q           = q_out_q;
    assign bus.R           = r_out_q;
    assign bus.div_by_zero = dbz_q;
endmodule

`default_nettype wire

// File: tb/tb_booth_divider_32.sv
// ============================================================================
// Module : tb_booth_divider_32
// Brief  : Scoreboard bench for booth_divider_32 (directed plus random pairs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_divider_32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_mis;
    int   n_spurious;
    exp_t sb[$];

    booth_divider_32_if #(.WIDTH(32)) bus ();

    booth_divider_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: C division semantics with the divider's zero/overflow rules.
    function automatic void model(input logic signed [31:0] a, input logic signed [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        z = 1'b0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Call at a negedge; leaves the bench at the negedge after acceptance.
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input bit push_it);
        int n;
        n = 0;
        while (!bus.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: ready timeout, got ready=%0b, expected 1", nm, bus.ready);
        end
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        if (push_it) sb.push_back('{eq, er, ez, cyc + 35, nm});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic        z;
        model(a, b, q, r, z);
        issue(nm, a, b, q, r, z, 1'b1);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (sb.size() == 0) begin
                n_spurious++;
                $display("FAIL spurious_valid: got valid at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_Q"}, bus.Q, e.q);
                chk({e.name, "_R"}, bus.R, e.r);
                chk({e.name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.z});
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_ready_low"}, {31'b0, bus.ready}, 32'h0);
            end
        end
    end

    initial begin
        n_vec = 0; n_mis = 0; n_spurious = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.ready}, 32'h1);
        chk("rst_valid", {31'b0, bus.valid}, 32'h0);
        chk("rst_Q", bus.Q, 32'h0);
        chk("rst_R", bus.R, 32'h0);
        chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("d45_3",      32'd45,           32'd3,           32'd15,          32'd0,    1'b0, 1'b1);
        issue("dm300_12",   -32'sd300,        32'd12,          -32'sd25,        32'd0,    1'b0, 1'b1);
        issue("d12345_m",   32'd12345,        -32'sd6789,      -32'sd1,         32'd5556, 1'b0, 1'b1);
        issue("dm7_2",      -32'sd7,          32'd2,           -32'sd3,         -32'sd1,  1'b0, 1'b1);
        issue("d7_m2",      32'd7,            -32'sd2,         -32'sd3,         32'd1,    1'b0, 1'b1);
        issue("d100_0",     32'd100,          32'd0,           32'hFFFF_FFFF,   32'd100,  1'b1, 1'b1);
        issue("dmin_m1",    32'h8000_0000,    32'hFFFF_FFFF,   32'h8000_0000,   32'd0,    1'b0, 1'b1);

        // Abandon an operation with reset: outputs clear at once, no valid follows.
        issue("abandon", 32'd50, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_Q", bus.Q, 32'h0);
        chk("arst_R", bus.R, 32'h0);
        chk("arst_valid", {31'b0, bus.valid}, 32'h0);
        chk("arst_ready", {31'b0, bus.ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue("dm1024_m2048", -32'sd1024, -32'sd2048, 32'd0, -32'sd1024, 1'b0, 1'b1);

        // start held high: second start mid-ITER is ignored, next op 36 cycles later.
        while (!bus.ready) @(negedge clk);
        begin
            int k;
            k = cyc;
            bus.start = 1'b1; bus.A = 32'd20; bus.B = 32'd6;
            sb.push_back('{32'd3, 32'd2, 1'b0, k + 35, "held_first"});
            repeat (10) @(negedge clk);
            bus.A = 32'd99; bus.B = 32'd1;
            while (cyc < k + 36) @(negedge clk);
            sb.push_back('{32'd99, 32'd0, 1'b0, k + 36 + 35, "held_second"});
            @(negedge clk);
            bus.start = 1'b0;
        end

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(0, 30)) - 32'd15;
            if (i % 8 == 3) a = 32'($urandom_range(0, 200)) - 32'd100;
            run("rand", a, b);
        end

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain_empty", sb.size(), 32'd0);
        repeat (40) @(negedge clk);
        chk("no_spurious", n_spurious, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + n_spurious);
        $finish;
    end

endmodule

`default_nettype wire
